// File: rtl/serial_word_loader_pkg.sv
// Shared types and constants for the serial word loader.
package serial_word_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    EMIT = 2'd3
  } state_t;

  localparam int unsigned WORD_MSB  = 63;
  localparam int unsigned ERR_CNT_W = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_SAT = 8'hFF;

endpackage

// File: rtl/serial_word_loader_sat_counter.sv
// Saturating event counter with synchronous active-high reset.
module sat_counter #(
  parameter int unsigned w = 8,
  parameter logic [w-1:0] sat = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [w-1:0] cnt
);

  // Count events, holding at the saturation value.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != sat)) begin
      cnt <= cnt + w'(1);
    end
  end

endmodule

// File: rtl/serial_word_loader.sv
// Deserialises a framed serial bit stream into a parallel word for the shiftreg stage.
module serial_word_loader
  import serial_word_loader_pkg::*;
#(
  parameter int unsigned width     = WORD_MSB,
  parameter bit          lsb_first = 1'b0,
  parameter bit          parity_en = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sin,
  input  logic                 sin_valid,
  output logic [width:0]       d_out,
  output logic                 wr,
  output logic                 busy,
  output logic                 perr,
  output logic                 ovr,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int unsigned CW = (width > 0) ? $clog2(width + 1) : 1;

  state_t         state, state_n;
  logic [width:0] sr, sr_n, shifted;
  logic [CW-1:0]  cnt, cnt_n;
  logic           par_acc, par_n;
  logic           load_c, perr_c, ovr_c;

  // Next-state, datapath and event decode.
  always_comb begin
    state_n = state;
    sr_n    = sr;
    cnt_n   = cnt;
    par_n   = par_acc;
    load_c  = 1'b0;
    perr_c  = 1'b0;
    ovr_c   = 1'b0;

    if (lsb_first) begin
      shifted = {sin, sr[width:1]};
    end else begin
      shifted = {sr[width-1:0], sin};
    end

    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = DATA;
          cnt_n   = '0;
          sr_n    = '0;
          par_n   = 1'b0;
        end
      end
      DATA: begin
        if (start) begin
          // Abort the partial frame; the bit in this cycle is not data.
          ovr_c   = 1'b1;
          state_n = DATA;
          cnt_n   = '0;
          sr_n    = '0;
          par_n   = 1'b0;
        end else if (sin_valid) begin
          sr_n  = shifted;
          par_n = par_acc ^ sin;
          if (cnt == CW'(width)) begin
            cnt_n = '0;
            if (parity_en) begin
              state_n = PAR;
            end else begin
              state_n = EMIT;
              load_c  = 1'b1;
            end
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      PAR: begin
        if (start) begin
          ovr_c   = 1'b1;
          state_n = DATA;
          cnt_n   = '0;
          sr_n    = '0;
          par_n   = 1'b0;
        end else if (sin_valid) begin
          if (sin == par_acc) begin
            state_n = EMIT;
            load_c  = 1'b1;
          end else begin
            perr_c  = 1'b1;
            state_n = IDLE;
          end
        end
      end
      EMIT: begin
        // wr is already high this cycle; a start here chains straight into the next frame.
        if (start) begin
          state_n = DATA;
          cnt_n   = '0;
          sr_n    = '0;
          par_n   = 1'b0;
        end else begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sr      <= '0;
      cnt     <= '0;
      par_acc <= 1'b0;
      d_out   <= '0;
      wr      <= 1'b0;
      busy    <= 1'b0;
      perr    <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      state   <= state_n;
      sr      <= sr_n;
      cnt     <= cnt_n;
      par_acc <= par_n;
      wr      <= load_c;
      busy    <= (state_n != IDLE);
      perr    <= perr_c;
      ovr     <= ovr_c;
      if (load_c) begin
        d_out <= sr_n;
      end
    end
  end

  sat_counter #(
    .w   (ERR_CNT_W),
    .sat (ERR_SAT)
  ) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (perr_c | ovr_c),
    .cnt (err_cnt)
  );

endmodule

// File: tb/tb_serial_word_loader.sv
// Scoreboard bench for serial_word_loader: stimulus pushes expected events, a monitor pops them.
module tb_serial_word_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sin;
  logic        sin_valid;
  logic [63:0] d_out;
  logic        wr;
  logic        busy;
  logic        perr;
  logic        ovr;
  logic [7:0]  err_cnt;

  int n_vec = 0;
  int n_err = 0;

  typedef enum int {EV_WR, EV_PERR, EV_OVR} ev_t;
  typedef struct {
    ev_t         kind;
    logic [63:0] word;
  } exp_t;

  exp_t exp_q[$];

  serial_word_loader #(
    .width     (63),
    .lsb_first (1'b0),
    .parity_en (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sin       (sin),
    .sin_valid (sin_valid),
    .d_out     (d_out),
    .wr        (wr),
    .busy      (busy),
    .perr      (perr),
    .ovr       (ovr),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic push(input ev_t kind, input logic [63:0] word);
    exp_t e;
    e.kind = kind;
    e.word = word;
    exp_q.push_back(e);
  endtask

  task automatic check_event(input ev_t kind, input logic [63:0] word);
    exp_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event: got kind %0d word %h, expected none", kind, word);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.word !== word) begin
        n_err++;
        $display("FAIL event_order: got kind %0d word %h expected kind %0d word %h",
                 kind, word, e.kind, e.word);
      end
    end
  endtask

  // Monitor: every output pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (wr === 1'b1)   check_event(EV_WR, d_out);
    if (perr === 1'b1) check_event(EV_PERR, 64'h0);
    if (ovr === 1'b1)  check_event(EV_OVR, 64'h0);
  end

  // Start strobe (with a junk valid bit) followed by 64 data bits MSB first and a parity bit.
  task automatic send_frame(input logic [63:0] word, input logic pbit, input bit gaps);
    start = 1'b1; sin_valid = 1'b1; sin = ~word[63];
    tick();
    start = 1'b0;
    for (int i = 63; i >= 0; i--) begin
      sin = word[i]; sin_valid = 1'b1;
      tick();
      if (gaps) begin
        sin_valid = 1'b0; sin = ~word[i];
        tick();
      end
    end
    sin = pbit; sin_valid = 1'b1;
    tick();
    sin_valid = 1'b0;
  endtask

  task automatic send_partial(input int n);
    start = 1'b1; sin_valid = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      sin = 1'b1; sin_valid = 1'b1;
      tick();
    end
    sin_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sin = 1'b0; sin_valid = 1'b0;
    tick(); tick(); tick();
    chk("reset_busy", 64'(busy), 64'h0);
    chk("reset_wr", 64'(wr), 64'h0);
    chk("reset_d_out", d_out, 64'h0);
    chk("reset_err_cnt", 64'(err_cnt), 64'h0);
    chk("reset_perr_ovr", 64'({perr, ovr}), 64'h0);
    rst = 1'b0;
    tick();

    // Sin_valid pulses in IDLE must be ignored.
    sin = 1'b1; sin_valid = 1'b1; tick(); tick(); sin_valid = 1'b0;
    chk("idle_ignore_busy", 64'(busy), 64'h0);

    // MSB-first word with correct (even) parity.
    push(EV_WR, 64'hDEADBEEF01234567);
    send_frame(64'hDEADBEEF01234567, 1'b0, 1'b0);
    chk("msb_wr", 64'(wr), 64'h1);
    chk("msb_d_out", d_out, 64'hDEADBEEF01234567);
    tick();
    chk("msb_wr_drop", 64'(wr), 64'h0);
    chk("msb_busy_drop", 64'(busy), 64'h0);

    // Same word with a bad parity bit.
    push(EV_PERR, 64'h0);
    send_frame(64'hDEADBEEF01234567, 1'b1, 1'b0);
    chk("perr_pulse", 64'(perr), 64'h1);
    chk("perr_err_cnt", 64'(err_cnt), 64'h1);
    chk("perr_d_out_hold", d_out, 64'hDEADBEEF01234567);
    chk("perr_no_wr", 64'(wr), 64'h0);
    tick();
    chk("perr_pulse_drop", 64'(perr), 64'h0);

    // Word 1 delivered with a gap after every valid bit.
    push(EV_WR, 64'h0000000000000001);
    send_frame(64'h0000000000000001, 1'b1, 1'b1);
    chk("gap_wr", 64'(wr), 64'h1);
    chk("gap_d_out", d_out, 64'h0000000000000001);
    tick();

    // Reset in the middle of a frame.
    send_partial(10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", 64'(busy), 64'h0);
    chk("midrst_d_out", d_out, 64'h0);
    chk("midrst_err_cnt", 64'(err_cnt), 64'h0);
    push(EV_WR, 64'h0123456789ABCDEF);
    send_frame(64'h0123456789ABCDEF, 1'b0, 1'b0);
    chk("midrst_d_out_after", d_out, 64'h0123456789ABCDEF);
    tick();

    // Abort after 20 bits, then a full all-ones frame.
    send_partial(20);
    push(EV_OVR, 64'h0);
    push(EV_WR, 64'hFFFFFFFFFFFFFFFF);
    send_frame(64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0);
    chk("abort_err_cnt", 64'(err_cnt), 64'h1);
    chk("abort_d_out", d_out, 64'hFFFFFFFFFFFFFFFF);

    // Back-to-back: each next start lands in the EMIT cycle of the previous frame.
    push(EV_WR, 64'h0123456789ABCDEF);
    send_frame(64'h0123456789ABCDEF, 1'b0, 1'b0);
    chk("b2b_first", d_out, 64'h0123456789ABCDEF);
    push(EV_WR, 64'hA5A5A5A5A5A5A5A5);
    send_frame(64'hA5A5A5A5A5A5A5A5, 1'b0, 1'b0);
    chk("b2b_second", d_out, 64'hA5A5A5A5A5A5A5A5);
    chk("b2b_err_cnt", 64'(err_cnt), 64'h1);
    tick();

    // Saturation: err_cnt starts at 1, 300 parity errors follow.
    for (int i = 0; i < 300; i++) begin
      push(EV_PERR, 64'h0);
      send_frame(64'h0, 1'b1, 1'b0);
      if (i == 252 || i == 253 || i == 254 || i == 299) begin
        chk("sat_err_cnt", 64'(err_cnt), 64'((i + 2 > 255) ? 255 : i + 2));
      end
    end
    tick(); tick();
    chk("sat_stable", 64'(err_cnt), 64'd255);
    chk("sat_d_out_hold", d_out, 64'hA5A5A5A5A5A5A5A5);

    tick(); tick(); tick();
    chk("queue_drained", 64'(exp_q.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_word_loader.md
Name: serial_word_loader

Overview:
- Upstream feeder for the 64-bit shiftreg stage.
- Deserialises a framed serial bit stream into a parallel word. Presents the word on d_out and issues a one-cycle wr pulse, which loads the shiftreg's d/wr inputs directly.
- Optional even-parity check per word. Errored or aborted frames never produce wr.

Parameters:
- width, 63, MSB index of the word (word is width+1 bits), matching the downstream shiftreg.
- lsb_first, 0, 0 = first received bit lands in d_out[width]; 1 = first bit lands in d_out[0].
- parity_en, 1, 1 = one even-parity bit follows the data bits; 0 = no parity bit.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  frame start strobe, sampled every cycle.
- sin  input  1  serial data bit, qualified by sin_valid.
- sin_valid  input  1  sin carries a valid bit this cycle.
- d_out  output  [width:0]  assembled word, to shiftreg d.
- wr  output  1  one-cycle load pulse, to shiftreg wr.
- busy  output  1  frame in progress (state != IDLE).
- perr  output  1  one-cycle pulse on parity mismatch.
- ovr  output  1  one-cycle pulse when start aborts a partial frame.
- err_cnt  output  8  saturating count of perr plus ovr events.

Behaviour:
- Reset: rst=1 at a rising edge clears all state. Next cycle: state=IDLE, shift register=0, bit counter=0, d_out=0, wr=0, busy=0, perr=0, ovr=0, err_cnt=0. Reset overrides all other inputs, including mid-frame.
- States: IDLE, DATA, PAR, EMIT.
- IDLE:
  - start=1 -> DATA, bit counter=0.
  - sin_valid is ignored in IDLE.
- DATA:
  - Each cycle with sin_valid=1: shift sin in (direction per lsb_first), accumulate running XOR, increment counter.
  - sin_valid=0: hold all state; there is no timeout.
  - When the valid bit with counter==width is taken: go to PAR if parity_en, else EMIT.
- PAR:
  - Waits for sin_valid=1 and compares sin with the data XOR (even parity: XOR of data and parity bit must be 0).
  - Match -> EMIT.
  - Mismatch -> perr=1 for one cycle, err_cnt+1, -> IDLE, d_out unchanged, no wr.
- EMIT (one cycle): d_out <= assembled word, wr=1 in the same cycle, -> IDLE.
- Latency: wr and the new d_out are asserted together, in the cycle after the edge that sampled the last bit (the parity bit if enabled).
- d_out is registered and stays stable until the next successful frame; it is never updated without wr.
- Start during DATA or PAR:
  - Partial frame discarded, ovr=1 for one cycle, err_cnt+1.
  - Restart DATA with counter=0; sin in that same cycle is not taken as data.
- Start during EMIT: the frame completes (wr asserted), then the FSM enters DATA directly with counter=0; no ovr.
- Start in IDLE: accepted normally; the sin_valid bit in the same cycle is not data.
- err_cnt saturates at 255. If perr and ovr cannot coincide, the counter adds at most 1 per cycle.
- Bit counter is sized by $clog2(width+1) and never exceeds width.
- Throughput: minimum frame is 1 + (width+1) + parity_en + 1 cycles, start to wr.
- No back-pressure: the downstream shiftreg accepts wr unconditionally.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=0, DATA=1, PAR=2, EMIT=3).
  - Default word MSB index (63).
  - err_cnt width (8).
  - Saturation constant (8'hFF).
- One natural sub-module: sat_counter (parameterised width, inc input, saturating), reusable for error counters elsewhere.
- The rest is a single module.

Test Plan:
- Reset mid-frame: rst=1 after 10 data bits -> next cycle busy=0, d_out=0, err_cnt=0; the following start plus 64 bits plus parity produces exactly one wr.
- MSB-first load (lsb_first=0, parity_en=1): send 64'hDEADBEEF_01234567 MSB first, parity bit 0 (popcount even) -> one cycle after the parity bit, wr=1 and d_out=64'hDEADBEEF01234567; wr=0 the next cycle.
- Parity error: same word, parity bit 1 -> perr pulses once, err_cnt=1, wr never asserted, d_out keeps its previous value.
- sin_valid gaps: 64'h1 sent with sin_valid toggling 1/0 every cycle -> d_out=64'h0000000000000001, wr exactly once, ~2x latency.
- Abort: start re-asserted after 20 bits -> ovr=1 for one cycle, err_cnt+1; the following full frame 64'hFFFFFFFFFFFFFFFF (parity 0) is loaded correctly.
- Saturation and back-to-back frames: 300 parity-error frames -> err_cnt=255, stable. Start asserted in the EMIT cycle -> two consecutive frames each produce wr, with no ovr.
